register_writeback: RTL and testbench
=====================================

// Module: register_writeback
// PURPOSE
//  Writeback arbiter directly upstream of the register file. It merges two result streams:
//   - M: load/memory results, which are the older instructions.
//   - A: ALU results.
//  Each stream uses a valid/ready handshake and has its own 1-entry skid buffer.
//  The block drives a single registered write port (wr_addr/wr_data/wr_en) into the register file.
//  Priority is M over A, so program order is preserved for same-register writes.
// PARAMETERS
//  DATA_W  32                  data width of one register
//  ADDR_L  32                  number of architectural registers
//  ADDR_W  Util_Math_log2(ADDR_L)  register address width
// PORTS
//  ctrl      in   Util_Control_T  clock = `Util_Control_clock(ctrl), reset = `Util_Control_reset(ctrl)
//  m_valid   in   1       memory result valid
//  m_ready   out  1       memory result accepted this cycle
//  m_addr    in   ADDR_W  destination register
//  m_data    in   DATA_W  load data
//  a_valid   in   1       ALU result valid
//  a_ready   out  1       ALU result accepted this cycle
//  a_addr    in   ADDR_W  destination register
//  a_data    in   DATA_W  ALU data
//  a_flush   in   1       discard buffered and incoming ALU result (exception squash)
//  wr_addr   out  ADDR_W  register-file write address (registered)
//  wr_data   out  DATA_W  register-file write data (registered)
//  wr_en     out  1       register-file write enable (registered)
//  busy      out  1       any skid entry valid, or wr_en high
// BEHAVIOUR
//  - Clock and reset: one clock. Reset is synchronous and active-high and is sampled on the rising edge.
//  - Reset values: both skids empty; wr_en=0; wr_addr=0; wr_data=0; busy=0. A reset mid-transfer drops all buffered results.
//  - Skid: holds {valid, addr, data}.
//    - x_ready = !skid_x.valid || pop_x (combinational on pop).
//    - Capture occurs when x_valid && x_ready.
//  - Arbiter: pop_m = skid_m.valid. pop_a = skid_a.valid && !skid_m.valid && !a_flush.
//  - Output register, loaded every cycle:
//    - wr_en <= pop && (sel_addr != 0).
//    - wr_addr/wr_data <= selected entry, or hold their previous value when nothing is popped.
//  - Register 0: writes to address 0 are popped and discarded; wr_en stays 0.
//  - Latency: an accept in cycle N gives skid valid in N+1 and wr_en high in N+2.
//    - M throughput is 1 per cycle.
//    - A throughput is 1 per cycle while M is idle; A stalls for every cycle that skid_m is valid.
//  - a_flush: clears skid_a and forces a_ready=0 in the same cycle. A result presented during flush is not accepted.
//    - An A entry already loaded into the output register still writes.
//  - Simultaneous capture and pop on the same skid: pop uses the old entry and capture loads the new one; no bubble.
//  - Both skids valid with the same address: M writes first and A writes next cycle, so the final value is A's.
//  - Arithmetic: none. Data passes through unmodified and widths are exact; no truncation.
// CONFIGURATION
//  REGISTER_WRITEBACK_STATS_EN
//   - Defined: adds output conflict_cnt [31:0]. It resets to 0 and increments on each cycle where both skids are valid, so A is stalled.
//     It wraps from 0xFFFFFFFF to 0, and a_flush does not affect it.
//   - Undefined: the port and counter are absent. All other behaviour is identical.
// STRUCTURE
//  - Shared package Register_pkg:
//    - typedef wb_req_t {addr[ADDR_W], data[DATA_W]}.
//    - localparam REG_ZERO = 0.
//  - Sub-module register_writeback_skid (1-entry valid/ready skid with a clear input), instantiated twice (M, A).
//    The arbiter and the output register stay in the top module.
// TESTING
//  1. Reset: assert reset 2 cycles with m_valid=a_valid=1 -> m_ready=a_ready=1, wr_en=0, busy=0 throughout reset.
//  2. Single A write: a_valid=1, a_addr=5, a_data=0xDEADBEEF at cycle N -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF in N+2 only.
//  3. Same-cycle conflict: m{3,0x11} and a{3,0x22} both accepted in N ->
//     wr{3,0x11} in N+2, wr{3,0x22} in N+3, a_ready=0 in N+1.
//  4. Register 0: m{0,0xFFFF} accepted -> m_ready stays 1, wr_en never asserts, busy falls after 2 cycles.
//  5. Flush: a{7,0x55} accepted in N, m_valid held 1 to stall A, a_flush=1 in N+2 ->
//     no write to register 7 ever, a_ready=0 in N+2.
//  6. Streaming: 8 back-to-back M writes to addresses 1..8 with A idle ->
//     m_ready constantly 1, wr_en high 8 consecutive cycles in order;
//     with STATS_EN, conflict_cnt=0, and after test 3 conflict_cnt=1.

Source files
------------

// File: rtl/register_writeback_pkg.sv
`default_nettype none
// ============================================================================
// register_writeback_pkg : default widths, request type and register-zero id
// Rev 1.0
// ============================================================================
package register_writeback_pkg;
   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_L = 32;
   localparam int WB_ADDR_W = $clog2(WB_ADDR_L);
   localparam int REG_ZERO  = 0;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_req_t;
endpackage
`default_nettype wire

// File: rtl/register_writeback_if.sv
`default_nettype none
// ============================================================================
// register_writeback_if : M/A result streams and register-file write port
// Optional REGISTER_WRITEBACK_STATS_EN adds conflict_cnt. Rev 1.0
// ============================================================================
interface register_writeback_if
   import register_writeback_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W
);
   logic              m_valid;
   logic              m_ready;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   logic              a_valid;
   logic              a_ready;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;
   logic              a_flush;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_en;
   logic              busy;
`ifdef REGISTER_WRITEBACK_STATS_EN
   logic [31:0]       conflict_cnt;
`endif

   modport master (
      output m_valid, m_addr, m_data, a_valid, a_addr, a_data, a_flush,
      input  m_ready, a_ready, wr_addr, wr_data, wr_en, busy
`ifdef REGISTER_WRITEBACK_STATS_EN
      , input conflict_cnt
`endif
   );

   modport slave (
      input  m_valid, m_addr, m_data, a_valid, a_addr, a_data, a_flush,
      output m_ready, a_ready, wr_addr, wr_data, wr_en, busy
`ifdef REGISTER_WRITEBACK_STATS_EN
      , output conflict_cnt
`endif
   );
endinterface
`default_nettype wire

// File: rtl/register_writeback_skid.sv
`default_nettype none
// ============================================================================
// register_writeback_skid : 1-entry valid/ready skid buffer with clear
// Rev 1.0
// ============================================================================
module register_writeback_skid
   import register_writeback_pkg::*;
#(
   parameter int W = 8
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic         clear,
   input  wire logic         in_valid,
   output logic              in_ready,
   input  wire logic [W-1:0] in_data,
   input  wire logic         pop,
   output logic              valid,
   output logic [W-1:0]      data
);
   // Popping frees the slot in the same cycle, so a full buffer streams without a bubble.
   assign in_ready = !clear && (!valid || pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (in_valid && in_ready) begin
         valid <= 1'b1;
         data  <= in_data;
      end else if (pop || clear) begin
         valid <= 1'b0;
      end
   end
endmodule
`default_nettype wire

// File: rtl/register_writeback.sv
`default_nettype none
// ============================================================================
// register_writeback : merges M (load) and A (ALU) results into one registered
// register-file write port, M first. Option: REGISTER_WRITEBACK_STATS_EN. Rev 1.0
// ============================================================================
module register_writeback
   import register_writeback_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_L = WB_ADDR_L,
   parameter int ADDR_W = $clog2(ADDR_L)
) (
   input  wire logic             clk,
   input  wire logic             rst,
   register_writeback_if.slave   bus
);
   localparam int REQ_W = ADDR_W + DATA_W;

   logic             m_held;
   logic             a_held;
   logic [REQ_W-1:0] m_entry;
   logic [REQ_W-1:0] a_entry;
   logic             pop_m;
   logic             pop_a;
   logic             pop;
   logic [REQ_W-1:0] sel_entry;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   register_writeback_skid #(.W(REQ_W)) u_skid_m (
      .clk      (clk),
      .rst      (rst),
      .clear    (1'b0),
      .in_valid (bus.m_valid),
      .in_ready (bus.m_ready),
      .in_data  ({bus.m_addr, bus.m_data}),
      .pop      (pop_m),
      .valid    (m_held),
      .data     (m_entry)
   );

   register_writeback_skid #(.W(REQ_W)) u_skid_a (
      .clk      (clk),
      .rst      (rst),
      .clear    (bus.a_flush),
      .in_valid (bus.a_valid),
      .in_ready (bus.a_ready),
      .in_data  ({bus.a_addr, bus.a_data}),
      .pop      (pop_a),
      .valid    (a_held),
      .data     (a_entry)
   );

   // M results are older, so they always win; a squashed A entry is never popped.
   assign pop_m     = m_held;
   assign pop_a     = a_held && !m_held && !bus.a_flush;
   assign pop       = pop_m || pop_a;
   assign sel_entry = pop_m ? m_entry : a_entry;
   assign sel_addr  = sel_entry[REQ_W-1:DATA_W];
   assign sel_data  = sel_entry[DATA_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
      end else begin
         bus.wr_en <= pop && (sel_addr != ADDR_W'(REG_ZERO));
         if (pop) begin
            bus.wr_addr <= sel_addr;
            bus.wr_data <= sel_data;
         end
      end
   end

   assign bus.busy = m_held || a_held || bus.wr_en;

`ifdef REGISTER_WRITEBACK_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.conflict_cnt <= '0;
      end else if (m_held && a_held) begin
         bus.conflict_cnt <= bus.conflict_cnt + 32'd1;
      end
   end
`endif
endmodule
`default_nettype wire

// File: tb/tb_register_writeback.sv
`default_nettype none
// ============================================================================
// tb_register_writeback : directed and random stimulus against a queue model
// Rev 1.0
// ============================================================================
module tb_register_writeback;
   import register_writeback_pkg::*;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   w7 = 0;

   register_writeback_if #(.DATA_W(WB_DATA_W), .ADDR_W(WB_ADDR_W)) bus ();

   register_writeback #(.DATA_W(WB_DATA_W), .ADDR_L(WB_ADDR_L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: each stream is a FIFO of accepted results; the port drains M before A.
   wb_req_t              mq[$];
   wb_req_t              aq[$];
   logic                 ew_en   = 1'b0;
   logic [WB_ADDR_W-1:0] ew_addr = '0;
   logic [WB_DATA_W-1:0] ew_data = '0;
   logic [31:0]          ecnt    = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic mv, input int ma, input logic [31:0] md,
                        input logic av, input int aa, input logic [31:0] ad, input logic fl);
      bus.m_valid = mv;
      bus.m_addr  = WB_ADDR_W'(ma);
      bus.m_data  = md;
      bus.a_valid = av;
      bus.a_addr  = WB_ADDR_W'(aa);
      bus.a_data  = ad;
      bus.a_flush = fl;
   endtask

   task automatic cycle();
      bit      pm, pa, cap_m, cap_a, fl, rs, both, exp_mr, exp_ar;
      wb_req_t sel, nm, na;
      sel = '0;
      #1;
      pm     = mq.size() != 0;
      pa     = !pm && aq.size() != 0 && !bus.a_flush;
      exp_mr = (mq.size() - (pm ? 1 : 0)) == 0;
      exp_ar = !bus.a_flush && ((aq.size() - (pa ? 1 : 0)) == 0);
      chk("m_ready", 64'(bus.m_ready), 64'(exp_mr));
      chk("a_ready", 64'(bus.a_ready), 64'(exp_ar));
      cap_m = bus.m_valid && exp_mr;
      cap_a = bus.a_valid && exp_ar;
      nm    = '{addr: bus.m_addr, data: bus.m_data};
      na    = '{addr: bus.a_addr, data: bus.a_data};
      fl    = bus.a_flush;
      rs    = rst;
      both  = mq.size() != 0 && aq.size() != 0;
      @(posedge clk);
      #1;
      if (rs) begin
         mq.delete();
         aq.delete();
         ew_en   = 1'b0;
         ew_addr = '0;
         ew_data = '0;
         ecnt    = '0;
      end else begin
         if (pm) sel = mq.pop_front();
         else if (pa) sel = aq.pop_front();
         if (fl) aq.delete();
         if (cap_m) mq.push_back(nm);
         if (cap_a) aq.push_back(na);
         ew_en = (pm || pa) && (sel.addr != WB_ADDR_W'(REG_ZERO));
         if (pm || pa) begin
            ew_addr = sel.addr;
            ew_data = sel.data;
         end
         if (both) ecnt = ecnt + 32'd1;
      end
      chk("wr_en", 64'(bus.wr_en), 64'(ew_en));
      chk("wr_addr", 64'(bus.wr_addr), 64'(ew_addr));
      chk("wr_data", 64'(bus.wr_data), 64'(ew_data));
      chk("busy", 64'(bus.busy), 64'(mq.size() != 0 || aq.size() != 0 || ew_en));
`ifdef REGISTER_WRITEBACK_STATS_EN
      chk("conflict_cnt", 64'(bus.conflict_cnt), 64'(ecnt));
`endif
      if (bus.wr_en === 1'b1 && bus.wr_addr == WB_ADDR_W'(7)) w7++;
   endtask

   initial begin
      // Reset held with both streams offering data.
      rst = 1'b1;
      drive(1, 4, 32'h1234, 1, 6, 32'h5678, 0);
      @(posedge clk);
      #1;
      cycle();
      cycle();

      // Single A write lands two cycles after acceptance.
      rst = 1'b0;
      drive(0, 0, 0, 1, 5, 32'hDEADBEEF, 0);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("t2_wr_en", 64'(bus.wr_en), 64'd1);
      chk("t2_wr_addr", 64'(bus.wr_addr), 64'd5);
      chk("t2_wr_data", 64'(bus.wr_data), 64'hDEADBEEF);
      cycle();
      chk("t2_wr_en_after", 64'(bus.wr_en), 64'd0);

      // Same-cycle conflict on register 3: M then A.
      drive(1, 3, 32'h11, 1, 3, 32'h22, 0);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 0);
      #1 chk("t3_a_ready", 64'(bus.a_ready), 64'd0);
      cycle();
      chk("t3_first", {31'd0, bus.wr_en, 27'd0, bus.wr_addr}, 64'h1_0000_0003);
      chk("t3_first_data", 64'(bus.wr_data), 64'h11);
      cycle();
      chk("t3_second", {31'd0, bus.wr_en, 27'd0, bus.wr_addr}, 64'h1_0000_0003);
      chk("t3_second_data", 64'(bus.wr_data), 64'h22);
`ifdef REGISTER_WRITEBACK_STATS_EN
      chk("t3_conflict_cnt", 64'(bus.conflict_cnt), 64'd1);
`endif

      // Register 0 write is swallowed.
      drive(1, 0, 32'hFFFF, 0, 0, 0, 0);
      cycle();
      chk("t4_busy_mid", 64'(bus.busy), 64'd1);
      drive(0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("t4_wr_en", 64'(bus.wr_en), 64'd0);
      chk("t4_busy_end", 64'(bus.busy), 64'd0);

      // Flush a stalled A entry behind a stream of M results.
      w7 = 0;
      drive(1, 9, 32'h77, 1, 7, 32'h55, 0);
      cycle();
      drive(1, 10, 32'h78, 0, 0, 0, 0);
      cycle();
      drive(1, 11, 32'h79, 1, 7, 32'h55, 1);
      #1 chk("t5_a_ready", 64'(bus.a_ready), 64'd0);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (4) cycle();
      chk("t5_no_write_7", 64'(w7), 64'd0);

      // Back-to-back M stream to registers 1..8 after a fresh reset.
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         drive(1, i, $urandom, 0, 0, 0, 0);
         cycle();
         if (i >= 2) chk("t6_order", {31'd0, bus.wr_en, 27'd0, bus.wr_addr}, 64'h1_0000_0000 | 64'(i - 1));
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("t6_last", {31'd0, bus.wr_en, 27'd0, bus.wr_addr}, 64'h1_0000_0008);
      cycle();
      chk("t6_idle", 64'(bus.wr_en), 64'd0);
`ifdef REGISTER_WRITEBACK_STATS_EN
      chk("t6_conflict_cnt", 64'(bus.conflict_cnt), 64'd0);
`endif

      // Random traffic with occasional flushes and resets.
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         drive($urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom,
               $urandom_range(0, 2) != 0, $urandom_range(0, 31), $urandom,
               $urandom_range(0, 9) == 0);
         cycle();
      end
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (4) cycle();
      chk("drained_busy", 64'(bus.busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
